// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Round-robin arbiter and access sequencer between two requesters and a
//   synchronous single-port memory. Exactly one command is in flight at a
//   time: each accepted command produces exactly one memory strobe. A read
//   returns its data as a one-cycle pulse to the requester that issued it.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid_x / req_ready_x     command handshake for requester x (0/1)
//   req_write_x                   1 = write, 0 = read
//   req_addr_x / req_wdata_x      command address / write data
//   rsp_valid_x / rsp_rdata_x     read-data pulse and held read data
//   mem_read / mem_write          memory strobes (one cycle, never together)
//   mem_addr / mem_data_in        memory address / write data (held)
//   mem_data_out                  memory read data, valid RD_LAT cycles
//                                 after the read strobe edge
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_0,
    output logic              req_ready_0,
    input  logic              req_write_0,
    input  logic [ADDR_W-1:0] req_addr_0,
    input  logic [DATA_W-1:0] req_wdata_0,
    output logic              rsp_valid_0,
    output logic [DATA_W-1:0] rsp_rdata_0,
    input  logic              req_valid_1,
    output logic              req_ready_1,
    input  logic              req_write_1,
    input  logic [ADDR_W-1:0] req_addr_1,
    input  logic [DATA_W-1:0] req_wdata_1,
    output logic              rsp_valid_1,
    output logic [DATA_W-1:0] rsp_rdata_1,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    // The wait counter only has to hold RD_LAT-1 down to 0.
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t             state_reg;
    logic               rr_ptr_reg;     // requester favoured when both are valid
    logic               op_write_reg;   // latched command type
    logic               op_id_reg;      // latched issuer
    logic [CNT_W-1:0]   wait_cnt_reg;

    logic               grant_valid;
    logic               grant_id;
    logic               sel_write;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    // Work-conserving grant: a lone valid requester wins regardless of the
    // pointer. rst_n gates the grant so ready is 0 while reset is held.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (rst_n && (state_reg == S_IDLE)) begin
            if (req_valid_0 && req_valid_1) begin
                grant_valid = 1'b1;
                grant_id    = rr_ptr_reg;
            end else if (req_valid_0) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end else if (req_valid_1) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
        end
    end

    assign req_ready_0 = grant_valid && !grant_id;
    assign req_ready_1 = grant_valid &&  grant_id;

    assign sel_write = grant_id ? req_write_1 : req_write_0;
    assign sel_addr  = grant_id ? req_addr_1  : req_addr_0;
    assign sel_wdata = grant_id ? req_wdata_1 : req_wdata_0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            rr_ptr_reg   <= 1'b0;
            op_write_reg <= 1'b0;
            op_id_reg    <= 1'b0;
            wait_cnt_reg <= '0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_addr     <= '0;
            mem_data_in  <= '0;
            rsp_valid_0  <= 1'b0;
            rsp_valid_1  <= 1'b0;
            rsp_rdata_0  <= '0;
            rsp_rdata_1  <= '0;
        end else begin
            // Response pulses last exactly one cycle.
            rsp_valid_0 <= 1'b0;
            rsp_valid_1 <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (grant_valid) begin
                        // Strobe is registered here so it is high for the
                        // whole ISSUE cycle.
                        op_write_reg <= sel_write;
                        op_id_reg    <= grant_id;
                        mem_addr     <= sel_addr;
                        mem_data_in  <= sel_wdata;
                        mem_write    <= sel_write;
                        mem_read     <= !sel_write;
                        rr_ptr_reg   <= !grant_id;
                        state_reg    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    mem_write <= 1'b0;
                    mem_read  <= 1'b0;
                    if (op_write_reg) begin
                        state_reg <= S_IDLE;
                    end else begin
                        wait_cnt_reg <= CNT_W'(RD_LAT - 1);
                        state_reg    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt_reg == '0) begin
                        if (op_id_reg) begin
                            rsp_valid_1 <= 1'b1;
                            rsp_rdata_1 <= mem_data_out;
                        end else begin
                            rsp_valid_0 <= 1'b1;
                            rsp_rdata_0 <= mem_data_out;
                        end
                        state_reg <= S_IDLE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - CNT_W'(1);
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter. A cycle-indexed behavioural model
//   (grant rule, busy-until cycle, predicted strobe/response cycles and a
//   shadow memory) is compared against every DUT output once per cycle on the
//   falling edge. Directed scenarios add literal expectations, then a
//   randomized phase drives both requesters.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int RD_LAT = 1;

    logic              clk;
    logic              rst_n;
    logic              req_valid_0, req_ready_0, req_write_0;
    logic [ADDR_W-1:0] req_addr_0;
    logic [DATA_W-1:0] req_wdata_0;
    logic              rsp_valid_0;
    logic [DATA_W-1:0] rsp_rdata_0;
    logic              req_valid_1, req_ready_1, req_write_1;
    logic [ADDR_W-1:0] req_addr_1;
    logic [DATA_W-1:0] req_wdata_1;
    logic              rsp_valid_1;
    logic [DATA_W-1:0] rsp_rdata_1;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0(req_valid_0), .req_ready_0(req_ready_0),
        .req_write_0(req_write_0), .req_addr_0(req_addr_0),
        .req_wdata_0(req_wdata_0), .rsp_valid_0(rsp_valid_0),
        .rsp_rdata_0(rsp_rdata_0),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1),
        .req_write_1(req_write_1), .req_addr_1(req_addr_1),
        .req_wdata_1(req_wdata_1), .rsp_valid_1(rsp_valid_1),
        .rsp_rdata_1(rsp_rdata_1),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous 32x8 memory: write on strobe, registered read data held.
    bit [DATA_W-1:0] tb_mem [32];
    bit [DATA_W-1:0] rd_q;
    always @(posedge clk) begin
        if (mem_write) tb_mem[mem_addr] <= mem_data_in;
        if (mem_read)  rd_q <= tb_mem[mem_addr];
    end
    assign mem_data_out = rd_q;

    int checks_total = 0;
    int checks_pass  = 0;

    // Behavioural model, indexed by cycle number.
    int cyc = 0;
    int m_ptr = 0;
    int m_free = 0;           // first cycle in which the arbiter is idle again
    int m_iss_cyc = -1;       // cycle holding the strobe
    int m_iss_w = 0;
    int m_rsp_cyc = -1;       // cycle holding the response pulse
    int m_rsp_id = 0;
    int m_rsp_data = 0;
    int m_rdata [2];
    int m_addr = 0;
    int m_din = 0;
    int m_mem [32];

    // Per-cycle observations used by the stimulus and directed checks.
    bit fire0, fire1, obs_rsp0, obs_rsp1, obs_mw;
    int obs_rdata0, obs_rdata1;

    task automatic chk(string name, int act, int exp);
        checks_total++;
        if (act == exp) checks_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic compare_step();
        int win;
        int w, a, d;
        if (!rst_n) begin
            chk("rst_ready_0", int'(req_ready_0), 0);
            chk("rst_ready_1", int'(req_ready_1), 0);
            chk("rst_mem_read", int'(mem_read), 0);
            chk("rst_mem_write", int'(mem_write), 0);
            chk("rst_mem_addr", int'(mem_addr), 0);
            chk("rst_mem_data_in", int'(mem_data_in), 0);
            chk("rst_rsp_valid_0", int'(rsp_valid_0), 0);
            chk("rst_rsp_valid_1", int'(rsp_valid_1), 0);
            chk("rst_rsp_rdata_0", int'(rsp_rdata_0), 0);
            chk("rst_rsp_rdata_1", int'(rsp_rdata_1), 0);
            m_ptr = 0; m_free = 0; m_iss_cyc = -1; m_rsp_cyc = -1;
            m_rdata[0] = 0; m_rdata[1] = 0; m_addr = 0; m_din = 0;
            cyc++;
            return;
        end
        if (cyc == m_rsp_cyc) m_rdata[m_rsp_id] = m_rsp_data;
        win = -1;
        if (cyc >= m_free) begin
            if (req_valid_0 && req_valid_1) win = m_ptr;
            else if (req_valid_0) win = 0;
            else if (req_valid_1) win = 1;
        end
        chk("ready_0", int'(req_ready_0), int'(win == 0));
        chk("ready_1", int'(req_ready_1), int'(win == 1));
        chk("mem_write", int'(mem_write), int'(cyc == m_iss_cyc && m_iss_w == 1));
        chk("mem_read", int'(mem_read), int'(cyc == m_iss_cyc && m_iss_w == 0));
        chk("mem_addr", int'(mem_addr), m_addr);
        chk("mem_data_in", int'(mem_data_in), m_din);
        chk("rsp_valid_0", int'(rsp_valid_0), int'(cyc == m_rsp_cyc && m_rsp_id == 0));
        chk("rsp_valid_1", int'(rsp_valid_1), int'(cyc == m_rsp_cyc && m_rsp_id == 1));
        chk("rsp_rdata_0", int'(rsp_rdata_0), m_rdata[0]);
        chk("rsp_rdata_1", int'(rsp_rdata_1), m_rdata[1]);
        if (win >= 0) begin
            w = (win == 1) ? int'(req_write_1) : int'(req_write_0);
            a = (win == 1) ? int'(req_addr_1)  : int'(req_addr_0);
            d = (win == 1) ? int'(req_wdata_1) : int'(req_wdata_0);
            m_iss_cyc = cyc + 1;
            m_iss_w   = w;
            m_addr    = a;
            m_din     = d;
            if (w == 1) begin
                m_mem[a] = d;
                m_free   = cyc + 2;
            end else begin
                m_rsp_cyc  = cyc + 2 + RD_LAT;
                m_rsp_id   = win;
                m_rsp_data = m_mem[a];
                m_free     = cyc + 2 + RD_LAT;
            end
            m_ptr = 1 - win;
            $display("txn cycle=%0d req=%0d %s addr=%0d data=0x%02h", cyc, win,
                     (w == 1) ? "WR" : "RD", a, (w == 1) ? d : m_mem[a]);
        end
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        fire0 = req_valid_0 && req_ready_0;
        fire1 = req_valid_1 && req_ready_1;
        obs_rsp0 = rsp_valid_0;
        obs_rsp1 = rsp_valid_1;
        obs_rdata0 = int'(rsp_rdata_0);
        obs_rdata1 = int'(rsp_rdata_1);
        obs_mw = mem_write;
        compare_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int id, bit w, int a, int d);
        if (id == 0) begin
            req_valid_0 = 1'b1; req_write_0 = w;
            req_addr_0 = ADDR_W'(a); req_wdata_0 = DATA_W'(d);
        end else begin
            req_valid_1 = 1'b1; req_write_1 = w;
            req_addr_1 = ADDR_W'(a); req_wdata_1 = DATA_W'(d);
        end
    endtask

    // Waits for the handshake of requester id, then drops its valid.
    task automatic wait_fire(int id);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            tick();
            if ((id == 0 && fire0) || (id == 1 && fire1)) ok = 1'b1;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        if (id == 0) req_valid_0 = 1'b0;
        else         req_valid_1 = 1'b0;
    endtask

    task automatic send(int id, bit w, int a, int d);
        set_req(id, w, a, d);
        wait_fire(id);
    endtask

    // Called right after an accept; lat = edges from accept edge to pulse.
    task automatic await_rsp(int id, output int lat, output int data);
        lat = -1;
        data = -1;
        for (int n = 1; n <= 20 && lat < 0; n++) begin
            tick();
            if (id == 0 && obs_rsp0) begin lat = n - 1; data = obs_rdata0; end
            if (id == 1 && obs_rsp1) begin lat = n - 1; data = obs_rdata1; end
        end
    endtask

    int lat, data, cnt;
    int grants [$];
    int exp_order [6];
    int rem0, rem1, a0, a1;

    initial begin
        for (int i = 0; i < 32; i++) m_mem[i] = 0;
        m_rdata[0] = 0; m_rdata[1] = 0;
        rst_n = 1'b0;
        req_valid_0 = 0; req_write_0 = 0; req_addr_0 = '0; req_wdata_0 = '0;
        req_valid_1 = 0; req_write_1 = 0; req_addr_1 = '0; req_wdata_1 = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Only req1 valid while the pointer favours req0: accepted at once.
        set_req(1, 1'b1, 7, 8'h77);
        tick();
        chk("t5_req1_same_cycle", int'(fire1), 1);
        chk("t5_req0_not_granted", int'(fire0), 0);
        req_valid_1 = 1'b0;

        // Write 5=A5 from req0, read it back through req1.
        send(0, 1'b1, 5, 8'hA5);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            cnt += int'(obs_mw);
        end
        chk("t2_write_strobe_cycles", cnt, 1);
        send(1, 1'b0, 5, 0);
        await_rsp(1, lat, data);
        chk("t2_rsp_latency", lat, RD_LAT + 1);
        chk("t2_rsp_rdata_1", data, 8'hA5);

        // Pointer now favours req1; reset must bring it back to req0.
        send(0, 1'b1, 9, 8'h99);
        tick();
        set_req(0, 1'b1, 10, 8'h10);
        set_req(1, 1'b1, 11, 8'h11);
        #1 rst_n = 1'b0;
        #1;
        chk("t1_async_ready_1", int'(req_ready_1), 0);
        chk("t1_async_mem_addr", int'(mem_addr), 0);
        chk("t1_async_mem_data_in", int'(mem_data_in), 0);
        chk("t1_async_rsp_rdata_1", int'(rsp_rdata_1), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("t1_first_grant_req0", int'(fire0), 1);
        chk("t1_first_grant_not_req1", int'(fire1), 0);
        req_valid_0 = 1'b0;
        wait_fire(1);

        // Fill with 0, then with data=addr, then read everything back.
        for (int i = 0; i < 32; i++) send(0, 1'b1, i, 0);
        for (int i = 0; i < 32; i++) send(0, 1'b1, i, i);
        for (int i = 0; i < 32; i++) begin
            send(0, 1'b0, i, 0);
            await_rsp(0, lat, data);
            chk("t4_readback", data, i);
        end
        chk("t4_addr31_value", data, 8'h1F);

        // Reset during WAIT aborts the read; the next command works.
        send(0, 1'b0, 3, 0);
        tick();
        #1 rst_n = 1'b0;
        #1;
        chk("t6_mem_read_dropped", int'(mem_read), 0);
        chk("t6_no_rsp_0", int'(rsp_valid_0), 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        send(1, 1'b0, 3, 0);
        await_rsp(1, lat, data);
        chk("t6_next_latency", lat, RD_LAT + 1);
        chk("t6_next_rdata", data, 3);

        // Both requesters keep valid for six reads: grants must alternate.
        rem0 = 3; rem1 = 3; a0 = 20; a1 = 24;
        set_req(0, 1'b0, a0, 0);
        set_req(1, 1'b0, a1, 0);
        for (int n = 0; n < 80 && grants.size() < 6; n++) begin
            tick();
            if (fire0) begin
                grants.push_back(0);
                rem0--; a0++;
                if (rem0 == 0) req_valid_0 = 1'b0;
                else req_addr_0 = ADDR_W'(a0);
            end
            if (fire1) begin
                grants.push_back(1);
                rem1--; a1++;
                if (rem1 == 0) req_valid_1 = 1'b0;
                else req_addr_1 = ADDR_W'(a1);
            end
        end
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
        exp_order = '{0, 1, 0, 1, 0, 1};
        chk("t3_grant_count", grants.size(), 6);
        for (int i = 0; i < 6 && i < grants.size(); i++)
            chk("t3_grant_order", grants[i], exp_order[i]);
        repeat (6) tick();

        // Randomized traffic; valid and payload held until accepted.
        for (int n = 0; n < 400; n++) begin
            if (!req_valid_0 && ($urandom_range(0, 1) == 1))
                set_req(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                        int'($urandom_range(0, 255)));
            if (!req_valid_1 && ($urandom_range(0, 1) == 1))
                set_req(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                        int'($urandom_range(0, 255)));
            tick();
            if (fire0) req_valid_0 = 1'b0;
            if (fire1) req_valid_1 = 1'b0;
        end
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
        repeat (8) tick();

        $display("%0d/%0d checks passed", checks_pass, checks_total);
        $finish;
    end

endmodule
